// File: rtl/logicnet_layer_sequencer.sv
// Folded LogicNet layer: one shared FANIN-input truth-table neuron evaluated NEURONS times
// per input vector, with the fan-in wiring fetched from an external connectivity ROM.
module logicnet_layer_sequencer #(
    parameter int IN_BITS = 16,
    parameter int NEURONS = 64,
    parameter int FANIN   = 8,
    parameter int IDX_W   = (IN_BITS > 1) ? $clog2(IN_BITS) : 1,
    parameter int NIDX_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_BITS-1:0]     in_data,
    output logic [NIDX_W-1:0]      conn_addr,
    input  logic [FANIN*IDX_W-1:0] conn_data,
    output logic [NIDX_W-1:0]      lut_sel,
    output logic [FANIN-1:0]       lut_addr,
    input  logic                   lut_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NEURONS-1:0]     out_data,
    output logic                   busy,
    output logic                   idx_err
);

    // Counter must reach NEURONS itself (the drain cycle), so it is one value wider than an index.
    localparam int                CNT_W     = $clog2(NEURONS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NEURONS);
    localparam logic [IDX_W:0]    IDX_LIMIT = (IDX_W + 1)'(IN_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q,    state_d;
    logic [IN_BITS-1:0]   vec_q,      vec_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 v1_q,       v1_d;
    logic [NIDX_W-1:0]    lut_sel_q,  lut_sel_d;
    logic [FANIN-1:0]     lut_addr_q, lut_addr_d;
    logic [NEURONS-1:0]   out_data_q, out_data_d;
    logic                 idx_err_q,  idx_err_d;

    logic                 issue;
    logic                 idx_bad;
    logic [FANIN-1:0]     gathered;

    // Gather: an out-of-range index matches no input bit and therefore contributes 0.
    always_comb begin
        gathered = '0;
        idx_bad  = 1'b0;
        for (int j = 0; j < FANIN; j++) begin
            if ({1'b0, conn_data[j*IDX_W +: IDX_W]} >= IDX_LIMIT) begin
                idx_bad = 1'b1;
            end
            for (int b = 0; b < IN_BITS; b++) begin
                if (conn_data[j*IDX_W +: IDX_W] == IDX_W'(b)) begin
                    gathered[j] = vec_q[b];
                end
            end
        end
    end

    // NOTE: every signal gets its default before any branch, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        v1_d       = 1'b0;
        lut_sel_d  = lut_sel_q;
        lut_addr_d = lut_addr_q;
        out_data_d = out_data_q;
        idx_err_d  = idx_err_q;
        issue      = 1'b0;

        // Stage 2 retires the neuron issued in the previous cycle.
        if (v1_q) begin
            for (int n = 0; n < NEURONS; n++) begin
                if (lut_sel_q == NIDX_W'(n)) begin
                    out_data_d[n] = lut_q;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    vec_d      = in_data;
                    cnt_d      = '0;
                    out_data_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q < CNT_LAST) begin
                    issue      = 1'b1;
                    v1_d       = 1'b1;
                    lut_addr_d = gathered;
                    lut_sel_d  = cnt_q[NIDX_W-1:0];
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (idx_bad) begin
                        idx_err_d = 1'b1;
                    end
                end else begin
                    // Drain cycle: the last neuron retires now, the vector is complete after it.
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            v1_q       <= 1'b0;
            lut_sel_q  <= '0;
            lut_addr_q <= '0;
            out_data_q <= '0;
            idx_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            v1_q       <= v1_d;
            lut_sel_q  <= lut_sel_d;
            lut_addr_q <= lut_addr_d;
            out_data_q <= out_data_d;
            idx_err_q  <= idx_err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign conn_addr = issue ? cnt_q[NIDX_W-1:0] : '0;
    assign lut_sel   = lut_sel_q;
    assign lut_addr  = lut_addr_q;
    assign out_data  = out_data_q;
    assign idx_err   = idx_err_q;

endmodule

// File: tb/tb_logicnet_layer_sequencer.sv
// Directed bench for logicnet_layer_sequencer: 4 neurons, 16 inputs, FANIN 8, with a
// connectivity ROM (neuron n reads bits n*4..n*4+3 twice) and an OR-of-inputs LUT.
module tb_logicnet_layer_sequencer;

    localparam int IN_BITS = 16;
    localparam int NEURONS = 4;
    localparam int FANIN   = 8;
    localparam int IDX_W   = 5;   // wide enough to express an out-of-range index
    localparam int NIDX_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [IN_BITS-1:0]     in_data;
    logic [NIDX_W-1:0]      conn_addr;
    logic [FANIN*IDX_W-1:0] conn_data;
    logic [NIDX_W-1:0]      lut_sel;
    logic [FANIN-1:0]       lut_addr;
    logic                   lut_q;
    logic                   out_valid;
    logic                   out_ready;
    logic [NEURONS-1:0]     out_data;
    logic                   busy;
    logic                   idx_err;
    logic                   bad_mode;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int accepts  = 0;
    int last_accept = 0;
    int nouts    = 0;
    logic [NEURONS-1:0] outs [16];
    logic ov_seen = 1'b0;

    logicnet_layer_sequencer #(
        .IN_BITS (IN_BITS),
        .NEURONS (NEURONS),
        .FANIN   (FANIN),
        .IDX_W   (IDX_W),
        .NIDX_W  (NIDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .conn_addr (conn_addr),
        .conn_data (conn_data),
        .lut_sel   (lut_sel),
        .lut_addr  (lut_addr),
        .lut_q     (lut_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .idx_err   (idx_err)
    );

    always #5 clk = ~clk;

    // Connectivity ROM; in bad_mode every field of neuron 2 points at nonexistent input 20.
    always_comb begin
        conn_data = '0;
        for (int j = 0; j < FANIN; j++) begin
            if (bad_mode && conn_addr == 2'd2)
                conn_data[j*IDX_W +: IDX_W] = 5'd20;
            else
                conn_data[j*IDX_W +: IDX_W] = 5'(int'(conn_addr) * 4 + (j % 4));
        end
    end

    assign lut_q = |lut_addr;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (in_valid && in_ready) begin
                accepts     = accepts + 1;
                last_accept = cyc;
            end
            if (out_valid) ov_seen = 1'b1;
            if (out_valid && out_ready && nouts < 16) begin
                outs[nouts] = out_data;
                nouts       = nouts + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outs(input int target, input string tag);
        for (int k = 0; k < 30; k++) begin
            if (nouts >= target) break;
            tick();
        end
        check(tag, 64'(nouts >= target), 64'd1);
    endtask

    task automatic accept_vec(input logic [IN_BITS-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    logic [FANIN-1:0] exp_addr_basic [NEURONS];
    logic [FANIN-1:0] exp_addr_bad   [NEURONS];
    int first_acc;
    int n0;

    initial begin
        exp_addr_basic = '{8'h00, 8'h00, 8'hFF, 8'h00};   // 16'h0F00: only neuron 2 sees ones
        exp_addr_bad   = '{8'hFF, 8'hFF, 8'h00, 8'hFF};   // 16'hFFFF with neuron 2 out of range

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; bad_mode = 1'b0;

        // 1 Reset
        tick(); tick();
        rst = 1'b0;
        check("rst in_ready",  64'(in_ready),  64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data",  64'(out_data),  64'd0);
        check("rst busy",      64'(busy),      64'd0);
        check("rst idx_err",   64'(idx_err),   64'd0);
        check("rst lut_sel",   64'(lut_sel),   64'd0);
        check("rst lut_addr",  64'(lut_addr),  64'd0);
        check("rst conn_addr", 64'(conn_addr), 64'd0);

        // 2 Basic vector, out_ready low so the DONE state can be held afterwards
        accept_vec(16'h0F00);
        check("basic accepted", 64'(accepts), 64'd1);
        check("run busy",       64'(busy),     64'd1);
        check("run in_ready",   64'(in_ready), 64'd0);
        for (int n = 0; n < NEURONS; n++) begin
            tick();
            check("basic lut_sel",  64'(lut_sel),  64'(n));
            check("basic lut_addr", 64'(lut_addr), 64'(exp_addr_basic[n]));
            check("basic out_valid early", 64'(out_valid), 64'd0);
        end
        tick();   // DONE visible, sampled high at edge accept+6
        check("basic out_valid", 64'(out_valid), 64'd1);
        check("basic out_data",  64'(out_data),  64'h4);
        check("basic idx_err",   64'(idx_err),   64'd0);

        // 3 Backpressure with a competing input offered
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp out_data",  64'(out_data),  64'h4);
            check("bp in_ready",  64'(in_ready),  64'd0);
        end
        check("bp not accepted", 64'(accepts), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp idle in_ready",  64'(in_ready),  64'd1);
        check("bp idle out_valid", 64'(out_valid), 64'd0);
        check("bp idle busy",      64'(busy),      64'd0);
        check("bp idle out_data",  64'(out_data),  64'h4);
        tick();
        check("idle out_data held", 64'(out_data), 64'h4);

        // 4 Back-to-back with out_ready held high
        n0 = nouts;
        accept_vec(16'hFFFF);
        first_acc = last_accept;
        in_valid = 1'b1;
        in_data  = 16'h0000;
        for (int k = 0; k < 20; k++) begin
            if (accepts >= 3) break;
            tick();
        end
        in_valid = 1'b0;
        check("b2b second accept", 64'(accepts), 64'd3);
        check("b2b spacing", 64'(last_accept - first_acc), 64'(NEURONS + 3));
        wait_outs(n0 + 2, "b2b outputs timeout");
        check("b2b out first",  64'(outs[n0]),     64'hF);
        check("b2b out second", 64'(outs[n0 + 1]), 64'h0);
        check("b2b idx_err",    64'(idx_err),      64'd0);

        // 5 Out-of-range fan-in index on neuron 2
        tick();
        bad_mode = 1'b1;
        n0 = nouts;
        accept_vec(16'hFFFF);
        for (int n = 0; n < NEURONS; n++) begin
            tick();
            check("bad lut_sel",  64'(lut_sel),  64'(n));
            check("bad lut_addr", 64'(lut_addr), 64'(exp_addr_bad[n]));
            check("bad idx_err",  64'(idx_err),  64'(n >= 2));
        end
        wait_outs(n0 + 1, "bad output timeout");
        check("bad out_data", 64'(outs[n0]), 64'b1011);
        bad_mode = 1'b0;
        tick();
        n0 = nouts;
        accept_vec(16'h0F00);
        wait_outs(n0 + 1, "after bad timeout");
        check("after bad out_data", 64'(outs[n0]), 64'h4);
        check("idx_err sticky",     64'(idx_err),  64'd1);

        // 6 Reset in the middle of RUN
        tick();
        accept_vec(16'hFFFF);
        ov_seen = 1'b0;
        tick(); tick();
        rst = 1'b1;   // sampled at edge accept+3
        tick();
        rst = 1'b0;
        check("midrst in_ready",  64'(in_ready),  64'd1);
        check("midrst busy",      64'(busy),      64'd0);
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst out_data",  64'(out_data),  64'd0);
        check("midrst idx_err",   64'(idx_err),   64'd0);
        for (int k = 0; k < 8; k++) tick();
        check("midrst no out_valid", 64'(ov_seen), 64'd0);
        n0 = nouts;
        accept_vec(16'hF000);
        wait_outs(n0 + 1, "post reset timeout");
        check("post reset out_data", 64'(outs[n0]), 64'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
